// File: rtl/seq_magnitude_comparator.sv
// seq_magnitude_comparator
// Multi-cycle magnitude comparator. Two WIDTH-bit operands are compared one
// SLICE-bit slice per clock, most-significant slice first. The compare is
// unsigned or two's-complement. Operands arrive on a valid/ready handshake and
// the result leaves on one.
//
// Optional feature: define CMP_EARLY_EXIT_EN so COMPARE stops at the first
// differing slice. Without it, all slices are always walked, which gives a
// fixed latency. The results are identical in both builds.
//
// WIDTH must be a positive multiple of SLICE.

module seq_magnitude_comparator #(
    parameter int WIDTH = 32,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             eq,
    output logic             gt,
    output logic             lt,
    output logic             busy
);

    localparam int N  = WIDTH / SLICE;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0]    TOP_IDX  = IW'(N - 1);
    localparam logic [SLICE-1:0] MSB_MASK = SLICE'(1) << (SLICE - 1);

    typedef enum logic [1:0] {
        IDLE,
        COMPARE,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             signed_q;
    logic [IW-1:0]    idx;
    logic             decided;
`ifndef CMP_EARLY_EXIT_EN
    logic             dec_gt;
    logic             dec_lt;
`endif

    logic [SLICE-1:0] sl_a;
    logic [SLICE-1:0] sl_b;
    logic             sl_gt;
    logic             sl_lt;
    logic             last_slice;

    assign start_ready = (state == IDLE);
    assign busy        = (state != IDLE);

    // Select the current slice of both operands. In signed mode the top slice has its sign bit flipped, which turns the signed order into an unsigned one.
    always_comb begin
        sl_a = '0;
        sl_b = '0;
        for (int i = 0; i < N; i++) begin
            if (idx == IW'(i)) begin
                sl_a = a_q[i*SLICE +: SLICE];
                sl_b = b_q[i*SLICE +: SLICE];
            end
        end
        if (signed_q && (idx == TOP_IDX)) begin
            sl_a = sl_a ^ MSB_MASK;
            sl_b = sl_b ^ MSB_MASK;
        end
        sl_gt      = (sl_a > sl_b);
        sl_lt      = (sl_a < sl_b);
        last_slice = (idx == '0);
    end

    // Control FSM with registered result outputs. The outputs stay cleared unless DONE is presenting a result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            signed_q  <= 1'b0;
            idx       <= '0;
            decided   <= 1'b0;
`ifndef CMP_EARLY_EXIT_EN
            dec_gt    <= 1'b0;
            dec_lt    <= 1'b0;
`endif
            res_valid <= 1'b0;
            eq        <= 1'b0;
            gt        <= 1'b0;
            lt        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_valid) begin
                        a_q      <= a;
                        b_q      <= b;
                        signed_q <= signed_mode;
                        idx      <= TOP_IDX;
                        decided  <= 1'b0;
`ifndef CMP_EARLY_EXIT_EN
                        dec_gt   <= 1'b0;
                        dec_lt   <= 1'b0;
`endif
                        state    <= COMPARE;
                    end
                end

                COMPARE: begin
`ifdef CMP_EARLY_EXIT_EN
                    if (!decided && (sl_gt || sl_lt)) begin
                        decided   <= 1'b1;
                        gt        <= sl_gt;
                        lt        <= sl_lt;
                        res_valid <= 1'b1;
                        state     <= DONE;
                    end else if (last_slice) begin
                        eq        <= 1'b1;
                        res_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        idx <= idx - IW'(1);
                    end
`else
                    if (!decided && (sl_gt || sl_lt)) begin
                        decided <= 1'b1;
                        dec_gt  <= sl_gt;
                        dec_lt  <= sl_lt;
                    end
                    if (last_slice) begin
                        res_valid <= 1'b1;
                        state     <= DONE;
                        if (decided) begin
                            gt <= dec_gt;
                            lt <= dec_lt;
                        end else if (sl_gt || sl_lt) begin
                            gt <= sl_gt;
                            lt <= sl_lt;
                        end else begin
                            eq <= 1'b1;
                        end
                    end else begin
                        idx <= idx - IW'(1);
                    end
`endif
                end

                DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        eq        <= 1'b0;
                        gt        <= 1'b0;
                        lt        <= 1'b0;
                        state     <= IDLE;
                    end
                end

                default: begin
                    res_valid <= 1'b0;
                    eq        <= 1'b0;
                    gt        <= 1'b0;
                    lt        <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// tb_seq_magnitude_comparator
// Scoreboard bench for seq_magnitude_comparator with WIDTH=32 and SLICE=4 (N=8).
// Expected results come from a full-width reference compare. Expected latency
// follows the CMP_EARLY_EXIT_EN build option.

module tb_seq_magnitude_comparator;

    localparam int WIDTH = 32;
    localparam int SLICE = 4;
    localparam int N     = WIDTH / SLICE;
    localparam int MAX_WAIT = 40;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start_valid = 1'b0;
    logic             start_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             signed_mode = 1'b0;
    logic             res_valid;
    logic             res_ready = 1'b0;
    logic             eq;
    logic             gt;
    logic             lt;
    logic             busy;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic eq;
        logic gt;
        logic lt;
        int   lat;
    } exp_t;

    exp_t sb[$];

    seq_magnitude_comparator #(
        .WIDTH(WIDTH),
        .SLICE(SLICE)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_valid(start_valid),
        .start_ready(start_ready),
        .a          (a),
        .b          (b),
        .signed_mode(signed_mode),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .eq         (eq),
        .gt         (gt),
        .lt         (lt),
        .busy       (busy)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Guard against a hung run
    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb, input logic msm);
        exp_t e;
        int   fd;
        e.eq = (ma == mb);
        if (msm)
            e.gt = ($signed(ma) > $signed(mb));
        else
            e.gt = (ma > mb);
        e.lt = !e.eq && !e.gt;
        fd = -1;
        for (int i = N - 1; i >= 0; i--) begin
            if (fd < 0 && ma[i*SLICE +: SLICE] != mb[i*SLICE +: SLICE])
                fd = i;
        end
`ifdef CMP_EARLY_EXIT_EN
        e.lat = (fd < 0) ? N : (N - fd);
`else
        e.lat = N;
`endif
        return e;
    endfunction

    // Run one operation: accept, wait for the result, optionally apply backpressure, then retire it.
    task automatic applyStimulus(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                                 input logic sm, input int hold);
        exp_t e;
        int   lat;
        @(negedge clk);
        checkOutput("start_ready_idle", start_ready, 1);
        a           = ta;
        b           = tb;
        signed_mode = sm;
        start_valid = 1'b1;
        sb.push_back(model(ta, tb, sm));
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        a           = $urandom;
        b           = $urandom;
        signed_mode = ~sm;
        lat = 0;
        while (lat < MAX_WAIT) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (res_valid) break;
        end
        e = sb.pop_front();
        checkOutput("latency", lat, e.lat);
        checkOutput("res_valid", res_valid, 1);
        checkOutput("result", {eq, gt, lt}, {e.eq, e.gt, e.lt});
        checkOutput("start_ready_done", start_ready, 0);
        checkOutput("busy_done", busy, 1);
        if (!res_valid) return;
        for (int c = 0; c < hold; c++) begin
            start_valid = (c == 1);
            @(posedge clk);
            @(negedge clk);
            start_valid = 1'b0;
            checkOutput("held_result", {res_valid, eq, gt, lt}, {1'b1, e.eq, e.gt, e.lt});
            checkOutput("held_ready", start_ready, 0);
        end
        res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        res_ready = 1'b0;
        checkOutput("retired", {res_valid, eq, gt, lt, busy, start_ready}, 6'b000001);
        if (hold > 0) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput("pulse_not_queued", busy, 0);
        end
    endtask

    initial begin
        logic seen;
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;

        // Reset held for two edges with start_valid high
        rst_n       = 1'b0;
        start_valid = 1'b1;
        a           = 32'h1;
        b           = 32'h2;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_outputs", {res_valid, eq, gt, lt, busy}, 5'b00000);
        rst_n       = 1'b1;
        start_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("reset_start_ready", start_ready, 1);
        checkOutput("reset_busy", busy, 0);

        // Directed cases
        applyStimulus(32'h12345678, 32'h12345678, 1'b0, 0);
        applyStimulus(32'h90000000, 32'h10000000, 1'b0, 0);
        applyStimulus(32'h90000000, 32'h10000000, 1'b1, 0);
        applyStimulus(32'h12345670, 32'h12345671, 1'b0, 0);
        applyStimulus(32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1, 0);
        applyStimulus(32'h80000001, 32'h80000002, 1'b1, 0);
        applyStimulus(32'h7FFFFFFF, 32'h80000000, 1'b0, 0);

        // Backpressure with an ignored start pulse
        applyStimulus(32'h80000000, 32'h7FFFFFFF, 1'b1, 5);

        // Random operands in both modes, some sharing upper slices
        for (int i = 0; i < 8; i++) begin
            ra = $urandom;
            rb = (i % 3 == 0) ? {ra[31:12], 12'($urandom)} : 32'($urandom);
            applyStimulus(ra, rb, 1'(i % 2), 0);
        end

        // Reset asserted on the third COMPARE cycle
        @(negedge clk);
        a           = 32'h0;
        b           = 32'h1;
        signed_mode = 1'b0;
        start_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_valid = 1'b0;
        checkOutput("midreset_busy_before", busy, 1);
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("midreset_idle", {busy, res_valid, start_ready}, 3'b001);
        rst_n = 1'b1;
        seen  = 1'b0;
        repeat (12) begin
            @(posedge clk);
            @(negedge clk);
            if (res_valid) seen = 1'b1;
        end
        checkOutput("midreset_no_result", seen, 0);
        applyStimulus(32'h0, 32'h0, 1'b0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_magnitude_comparator.md
Name: seq_magnitude_comparator

Overview:
- Parametrised, multi-cycle successor to the team's 4-bit/8-bit combinational comparators.
- Compares two WIDTH-bit operands one SLICE-bit slice per clock, most-significant slice first.
- Supports unsigned and two's-complement signed modes.
- Uses valid/ready handshakes on input and output so it can sit between pipelined datapath stages without wide combinational compare paths.

Parameters:
- WIDTH, 32, operand width in bits; must be a positive multiple of SLICE.
- SLICE, 4, bits compared per cycle; N = WIDTH/SLICE slices (N=1 legal).

Ports:
- clk  input  1  clock, all logic on rising edge
- rst_n  input  1  synchronous active-low reset
- start_valid  input  1  operands and mode present
- start_ready  output  1  block can accept operands
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- signed_mode  input  1  1 = two's-complement compare, 0 = unsigned
- res_valid  output  1  result present
- res_ready  input  1  consumer accepts result
- eq  output  1  a == b
- gt  output  1  a > b
- lt  output  1  a < b
- busy  output  1  state != IDLE

Behaviour:
- Interface (already decided): one clock, clk; reset rst_n is synchronous and active-low.
- FSM states: IDLE, COMPARE, DONE.
- Reset (rst_n low at an edge): state=IDLE, res_valid=0, eq=gt=lt=0, busy=0, slice index and decided flag cleared. start_ready=1 from the first cycle after reset.
- start_ready = (state==IDLE), combinational from state only.
- Accept edge: start_valid & start_ready. Latch a, b, signed_mode; index=N-1; decided=0; state goes to COMPARE.
- COMPARE, each cycle: compare latched slice[index] of a vs b as unsigned SLICE-bit values.
- Signed mode: the top slice (index N-1) is compared with the MSB of both operands inverted. Lower slices are always unsigned.
- First differing slice: decided=1, gt/lt result captured.
- index==0 and no difference found: eq result captured.
- Leaving COMPARE: when a result is final, state goes to DONE at that edge; otherwise index decrements.
- Latency: res_valid rises k edges after the accept edge, where k = number of slices examined. Equal operands give k=N.
- DONE: res_valid=1; exactly one of eq/gt/lt is 1, held stable until res_valid & res_ready, then state goes to IDLE at that edge.
- eq, gt and lt are 0 whenever res_valid=0.
- No accept in DONE: start_valid while in DONE or COMPARE is ignored and not queued. Minimum issue interval is k+2 cycles.
- Operand stability: inputs a/b/signed_mode may change freely after the accept edge; only latched copies are used.
- Reset mid-operation: rst_n low in COMPARE or DONE returns to IDLE at that edge. Any pending result is discarded; res_valid=0 next cycle.
- res_ready while res_valid=0 has no effect.

Optional Feature:
- Macro: CMP_EARLY_EXIT_EN.
- Defined: COMPARE exits at the first differing slice, so k = (N - index_of_first_difference).
- Undefined: all N slices are always examined.
  - The decided flag makes the first difference sticky; lower slices cannot overwrite it.
  - k = N for every operand pair, giving fixed latency.
- Result values are identical either way; only latency differs.

Test Plan:
All scenarios use WIDTH=32, SLICE=4 (N=8).
1. Reset: rst_n=0 for 2 edges with start_valid=1 -> res_valid=0, eq=gt=lt=0, busy=0; start_ready=1 after release.
2. Equal operands: a=b=0x12345678, signed_mode=0 -> res_valid 8 edges after accept, eq=1, gt=lt=0, with or without the macro.
3. Top-slice difference and signed mode:
   - a=0x90000000, b=0x10000000, signed_mode=0 -> gt=1.
   - Same operands, signed_mode=1 -> lt=1.
   - Latency is 1 edge with CMP_EARLY_EXIT_EN and 8 edges without.
4. Bottom-slice difference: a=0x12345670, b=0x12345671 -> lt=1 after 8 edges in both builds. Also a=0xFFFFFFFF, b=0xFFFFFFFE, signed_mode=1 -> gt=1.
5. Backpressure: hold res_ready=0 for 5 cycles after res_valid rises, pulse start_valid -> result held stable, start_ready=0, pulse ignored. res_ready=1 -> IDLE next edge, start_ready=1.
6. Reset mid-compare: rst_n=0 on the 3rd COMPARE cycle of a=0x0, b=0x1 (macro undefined) -> IDLE at that edge, res_valid never asserts. A new operation after release completes normally with eq=1 for a=b=0x0.
